// File: rtl/sys_regs_star.sv
// Star interconnect between the core's system-register read/write ports and up to 32 register nodes.
// Requests fan out combinationally; the registered node response is steered back by the captured group.
module sys_regs_star #(
    parameter int NR_NODES  = 32,
    parameter int REG_WIDTH = 64
) (
    input  logic                          clk,
    input  logic                          rst,

    input  logic                          rd_en,
    input  logic [4:0]                    rd_group,
    input  logic [2:0]                    rd_regnum,
    input  logic [1:0]                    rd_plevel,
    output logic                          rd_valid,
    output logic [REG_WIDTH-1:0]          rd_val,

    input  logic                          wr_en,
    input  logic [4:0]                    wr_group,
    input  logic [2:0]                    wr_regnum,
    input  logic [1:0]                    wr_plevel,
    input  logic [REG_WIDTH-1:0]          wr_val,

    output logic [NR_NODES-1:0]           node_rd_en,
    output logic [3*NR_NODES-1:0]         node_rd_regnum,
    output logic [2*NR_NODES-1:0]         node_rd_plevel,
    input  logic [NR_NODES-1:0]           node_rd_valid,
    input  logic [REG_WIDTH*NR_NODES-1:0] node_rd_val,

    output logic [NR_NODES-1:0]           node_wr_en,
    output logic [3*NR_NODES-1:0]         node_wr_regnum,
    output logic [2*NR_NODES-1:0]         node_wr_plevel,
    output logic [REG_WIDTH*NR_NODES-1:0] node_wr_val
);

    logic                 pend;
    logic [4:0]           grp_q;
    logic                 sel_valid;
    logic [REG_WIDTH-1:0] sel_val;

    always_comb begin
        node_rd_en = '0;
        node_wr_en = '0;
        for (int i = 0; i < NR_NODES; i++) begin
            node_rd_en[i] = rd_en && !rst && (rd_group == 5'(i));
            node_wr_en[i] = wr_en && !rst && (wr_group == 5'(i));
        end
    end

    assign node_rd_regnum = {NR_NODES{rd_regnum}};
    assign node_rd_plevel = {NR_NODES{rd_plevel}};
    assign node_wr_regnum = {NR_NODES{wr_regnum}};
    assign node_wr_plevel = {NR_NODES{wr_plevel}};
    assign node_wr_val    = {NR_NODES{wr_val}};

    always_ff @(posedge clk) begin
        if (rst) begin
            pend  <= 1'b0;
            grp_q <= '0;
        end else begin
            pend <= rd_en;
            if (rd_en)
                grp_q <= rd_group;
        end
    end

    // Groups with no node never match, so reads to them stay unanswered.
    always_comb begin
        sel_valid = 1'b0;
        sel_val   = '0;
        for (int i = 0; i < NR_NODES; i++) begin
            if (grp_q == 5'(i)) begin
                sel_valid = node_rd_valid[i];
                sel_val   = node_rd_val[i*REG_WIDTH +: REG_WIDTH];
            end
        end
    end

    // Reset in the response cycle squashes a read still in flight.
    assign rd_valid = pend && sel_valid && !rst;
    assign rd_val   = rd_valid ? sel_val : '0;

endmodule

// File: tb/tb_sys_regs_star.sv
// Directed plus randomized bench for sys_regs_star with behavioural node stubs and a request-level model.
module tb_sys_regs_star;
    localparam int NR = 32;
    localparam int W  = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          rd_en, wr_en;
    logic [4:0]    rd_group, wr_group;
    logic [2:0]    rd_regnum, wr_regnum;
    logic [1:0]    rd_plevel, wr_plevel;
    logic [W-1:0]  wr_val;
    logic          rd_valid;
    logic [W-1:0]  rd_val;
    logic [NR-1:0] node_rd_en, node_wr_en, node_rd_valid;
    logic [3*NR-1:0] node_rd_regnum, node_wr_regnum;
    logic [2*NR-1:0] node_rd_plevel, node_wr_plevel;
    logic [W*NR-1:0] node_rd_val, node_wr_val;

    sys_regs_star #(.NR_NODES(NR), .REG_WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .rd_en(rd_en), .rd_group(rd_group), .rd_regnum(rd_regnum), .rd_plevel(rd_plevel),
        .rd_valid(rd_valid), .rd_val(rd_val),
        .wr_en(wr_en), .wr_group(wr_group), .wr_regnum(wr_regnum), .wr_plevel(wr_plevel),
        .wr_val(wr_val),
        .node_rd_en(node_rd_en), .node_rd_regnum(node_rd_regnum), .node_rd_plevel(node_rd_plevel),
        .node_rd_valid(node_rd_valid), .node_rd_val(node_rd_val),
        .node_wr_en(node_wr_en), .node_wr_regnum(node_wr_regnum), .node_wr_plevel(node_wr_plevel),
        .node_wr_val(node_wr_val)
    );

    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    // Node stubs: each node holds a value and answers one cycle after being strobed if its mask bit is set.
    logic [W-1:0]  stub_val [NR];
    logic [NR-1:0] resp_mask;
    logic [NR-1:0] spur;
    logic [NR-1:0] prev_req;

    // Reference: the outstanding read issued in the previous cycle, if any.
    logic          m_pend;
    int            m_grp;

    function automatic logic [NR-1:0] onehot(input logic [4:0] g);
        return (int'(g) < NR) ? (NR'(1) << g) : '0;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic r, input logic re, input logic [4:0] rg, input logic [2:0] rn,
                         input logic [1:0] rp, input logic we, input logic [4:0] wg,
                         input logic [2:0] wn, input logic [1:0] wp, input logic [W-1:0] wv);
        rst = r; rd_en = re; rd_group = rg; rd_regnum = rn; rd_plevel = rp;
        wr_en = we; wr_group = wg; wr_regnum = wn; wr_plevel = wp; wr_val = wv;
        node_rd_valid = (prev_req & resp_mask) | spur;
        for (int i = 0; i < NR; i++)
            node_rd_val[i*W +: W] = stub_val[i];
        #2;
    endtask

    task automatic check_all();
        logic          ev;
        logic [W-1:0]  evl;
        chk("node_rd_en", 128'(node_rd_en), 128'((rd_en && !rst) ? onehot(rd_group) : '0));
        chk("node_wr_en", 128'(node_wr_en), 128'((wr_en && !rst) ? onehot(wr_group) : '0));
        chk("rd_regnum_bcast", 128'(node_rd_regnum), 128'({NR{rd_regnum}}));
        chk("rd_plevel_bcast", 128'(node_rd_plevel), 128'({NR{rd_plevel}}));
        chk("wr_regnum_bcast", 128'(node_wr_regnum), 128'({NR{wr_regnum}}));
        chk("wr_plevel_bcast", 128'(node_wr_plevel), 128'({NR{wr_plevel}}));
        for (int i = 0; i < NR; i++)
            chk($sformatf("wr_val_bcast[%0d]", i), 128'(node_wr_val[i*W +: W]), 128'(wr_val));
        ev  = m_pend && !rst && (m_grp < NR) && node_rd_valid[m_grp];
        evl = ev ? stub_val[m_grp] : '0;
        chk("rd_valid", 128'(rd_valid), 128'(ev));
        chk("rd_val", 128'(rd_val), 128'(evl));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rst) begin
            m_pend = 1'b0;
            m_grp  = 0;
        end else begin
            m_pend = rd_en;
            if (rd_en) m_grp = int'(rd_group);
        end
        prev_req = (rd_en && !rst) ? onehot(rd_group) : '0;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 5'd0, 3'd0, 2'd0, 1'b0, 5'd0, 3'd0, 2'd0, '0);
        check_all();
        tick();
    endtask

    initial begin
        m_pend = 1'b0; m_grp = 0; prev_req = '0; spur = '0; resp_mask = '1;
        for (int i = 0; i < NR; i++) stub_val[i] = {$urandom, $urandom};
        stub_val[10] = 64'hCAFEF00DDEADBEEF;
        stub_val[2]  = 64'h0202020202020202;

        // Reset with both requests active: no strobes, broadcasts still follow.
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b1, 5'd10, 3'd5, 2'd2, 1'b1, 5'd10, 3'd6, 2'd1, 64'h0123456789ABCDEF);
            check_all();
            chk("rst_rd_en_zero", 128'(node_rd_en), 128'(0));
            chk("rst_wr_en_zero", 128'(node_wr_en), 128'(0));
            chk("rst_rd_valid", 128'(rd_valid), 128'(0));
            tick();
        end
        idle();

        // Write decode to node 10 and node 31.
        drive(1'b0, 1'b0, 5'd0, 3'd0, 2'd0, 1'b1, 5'd10, 3'd7, 2'd0, 64'h1122334455667788);
        check_all();
        chk("wr_decode_10", 128'(node_wr_en), 128'(32'h0000_0400));
        chk("wr_val_node0", 128'(node_wr_val[W-1:0]), 128'(64'h1122334455667788));
        tick();
        drive(1'b0, 1'b0, 5'd0, 3'd0, 2'd0, 1'b1, 5'd31, 3'd7, 2'd0, 64'h1122334455667788);
        check_all();
        chk("wr_decode_31", 128'(node_wr_en), 128'(32'h8000_0000));
        tick();

        // Read round-trip through node 10.
        drive(1'b0, 1'b1, 5'd10, 3'd7, 2'd0, 1'b0, 5'd0, 3'd0, 2'd0, '0);
        check_all();
        chk("rd_decode_10", 128'(node_rd_en), 128'(32'h0000_0400));
        tick();
        drive(1'b0, 1'b0, 5'd0, 3'd0, 2'd0, 1'b0, 5'd0, 3'd0, 2'd0, '0);
        check_all();
        chk("rt_valid", 128'(rd_valid), 128'(1));
        chk("rt_val", 128'(rd_val), 128'(64'hCAFEF00DDEADBEEF));
        tick();
        drive(1'b0, 1'b0, 5'd0, 3'd0, 2'd0, 1'b0, 5'd0, 3'd0, 2'd0, '0);
        check_all();
        chk("rt_valid_drop", 128'(rd_valid), 128'(0));
        tick();

        // Silent node 3 while node 10 raises valid on its own.
        resp_mask = ~(NR'(1) << 3);
        drive(1'b0, 1'b1, 5'd3, 3'd1, 2'd3, 1'b0, 5'd0, 3'd0, 2'd0, '0);
        check_all();
        tick();
        spur = NR'(1) << 10;
        for (int k = 0; k < 2; k++) begin
            drive(1'b0, 1'b0, 5'd0, 3'd0, 2'd0, 1'b0, 5'd0, 3'd0, 2'd0, '0);
            check_all();
            chk("silent_no_valid", 128'(rd_valid), 128'(0));
            tick();
        end
        spur = '0; resp_mask = '1;

        // Simultaneous read of node 10 and write of node 5.
        drive(1'b0, 1'b1, 5'd10, 3'd2, 2'd1, 1'b1, 5'd5, 3'd4, 2'd1, 64'hFFFF0000FFFF0000);
        check_all();
        chk("sim_rd_en", 128'(node_rd_en), 128'(32'h0000_0400));
        chk("sim_wr_en", 128'(node_wr_en), 128'(32'h0000_0020));
        tick();
        drive(1'b0, 1'b0, 5'd0, 3'd0, 2'd0, 1'b0, 5'd0, 3'd0, 2'd0, '0);
        check_all();
        chk("sim_rd_val", 128'(rd_val), 128'(64'hCAFEF00DDEADBEEF));
        tick();

        // Reset in the cycle after a read squashes the response.
        drive(1'b0, 1'b1, 5'd10, 3'd0, 2'd0, 1'b0, 5'd0, 3'd0, 2'd0, '0);
        check_all();
        tick();
        drive(1'b1, 1'b0, 5'd0, 3'd0, 2'd0, 1'b0, 5'd0, 3'd0, 2'd0, '0);
        check_all();
        chk("midrst_valid", 128'(rd_valid), 128'(0));
        tick();
        idle();

        // Streaming reads alternating nodes 10 and 2.
        for (int k = 0; k < 8; k++) begin
            drive(1'b0, 1'b1, (k % 2 == 0) ? 5'd10 : 5'd2, 3'(k), 2'(k), 1'b0, 5'd0, 3'd0, 2'd0, '0);
            check_all();
            if (k > 0)
                chk("stream_val", 128'(rd_val), 128'((k % 2 == 1) ? 64'hCAFEF00DDEADBEEF : 64'h0202020202020202));
            tick();
        end
        idle();

        // Randomized traffic: occasional resets, silent nodes and spurious valids.
        for (int k = 0; k < 300; k++) begin
            for (int i = 0; i < NR; i++) stub_val[i] = {$urandom, $urandom};
            resp_mask = NR'($urandom | $urandom);
            spur      = NR'($urandom & $urandom & $urandom);
            drive(($urandom_range(0, 15) == 0), 1'($urandom), 5'($urandom), 3'($urandom),
                  2'($urandom), 1'($urandom), 5'($urandom), 3'($urandom), 2'($urandom),
                  {$urandom, $urandom});
            check_all();
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
